magnetron_sr_driver: RTL and testbench

Synchronous controller that produces the set (S) and reset (R) pulses feeding the magnetron SR latch. Turns operator start/stop buttons, the door interlock and the cook-timer expiry into clean, mutually exclusive, fixed-width S/R pulses, and enforces a minimum off-time before the magnetron can be re-armed. Sits between the panel/timer logic and the magnetron latch in the level-3 magnetron path.

---
 rtl/magnetron_pkg.sv | 32 +++
 rtl/btn_debounce_edge.sv | 60 ++++++
 rtl/magnetron_sr_driver.sv | 108 ++++++++++
 tb/tb_magnetron_sr_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/magnetron_pkg.sv
// ============================================================================
// magnetron_pkg : state encoding and default timing for magnetron_sr_driver
// Rev 1.0
// ============================================================================
`default_nettype none

package magnetron_pkg;

   localparam logic [2:0] ST_OFF       = 3'd0;
   localparam logic [2:0] ST_SET_PULSE = 3'd1;
   localparam logic [2:0] ST_ON        = 3'd2;
   localparam logic [2:0] ST_RST_PULSE = 3'd3;
   localparam logic [2:0] ST_COOLDOWN  = 3'd4;

   typedef enum logic [2:0] {
      OFF       = ST_OFF,
      SET_PULSE = ST_SET_PULSE,
      ON        = ST_ON,
      RST_PULSE = ST_RST_PULSE,
      COOLDOWN  = ST_COOLDOWN
   } state_t;

   localparam int DEFAULT_PULSE_LEN      = 2;
   localparam int DEFAULT_MIN_OFF_CYCLES = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_edge.sv
// ============================================================================
// btn_debounce_edge : optional stability filter plus rising-edge detector.
// Filter present only when MAGNETRON_DEBOUNCE_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce_edge #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt,
   output logic rise
);

   logic prev;

   if (DEB_CYCLES < 2) begin : g_deb_cycles_check
      $error("btn_debounce_edge: DEB_CYCLES must be >= 2");
   end

`ifdef MAGNETRON_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES);

   logic [CW-1:0] cnt;
   logic          filt_q;

   // filt_q follows raw only after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         cnt    <= '0;
      end else if (raw != filt_q) begin
         if (cnt == CW'(DEB_CYCLES - 1)) begin
            filt_q <= raw;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   assign filt = filt_q;
`else
   assign filt = raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= filt;
   end

   assign rise = filt & ~prev;

endmodule

`default_nettype wire

// File: rtl/magnetron_sr_driver.sv
// ============================================================================
// magnetron_sr_driver : mutually exclusive fixed-width S/R pulses for the
// magnetron latch, with enforced cooldown. Optional MAGNETRON_DEBOUNCE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module magnetron_sr_driver
   import magnetron_pkg::*;
#(
   parameter int PULSE_LEN      = DEFAULT_PULSE_LEN,
   parameter int MIN_OFF_CYCLES = DEFAULT_MIN_OFF_CYCLES,
   parameter int DEB_CYCLES     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_btn,
   input  logic stop_btn,
   input  logic door_open,
   input  logic timer_done,
   output logic S,
   output logic R,
   output logic mag_on,
   output logic cooling
);

   localparam int CNT_W = $clog2(max_int(PULSE_LEN, MIN_OFF_CYCLES) + 1);
   localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN);
   localparam logic [CNT_W-1:0] OFF_CNT   = CNT_W'(MIN_OFF_CYCLES);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             start_filt, stop_filt;
   logic             start_rise, stop_rise;
   logic             unused_filt;

   btn_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_start (
      .clk(clk), .rst_n(rst_n), .raw(start_btn), .filt(start_filt), .rise(start_rise)
   );

   btn_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
      .clk(clk), .rst_n(rst_n), .raw(stop_btn), .filt(stop_filt), .rise(stop_rise)
   );

   assign unused_filt = start_filt & stop_filt;

   always_comb begin
      state_nx = state;
      cnt_nx   = (cnt != '0) ? cnt - 1'b1 : cnt;
      case (state)
         OFF: begin
            if (start_rise && !door_open && !timer_done) begin
               state_nx = SET_PULSE;
               cnt_nx   = PULSE_CNT;
            end
         end
         SET_PULSE: begin
            if (door_open) begin
               state_nx = RST_PULSE;
               cnt_nx   = PULSE_CNT;
            end else if (cnt == CNT_W'(1)) begin
               state_nx = ON;
            end
         end
         ON: begin
            if (stop_rise || door_open || timer_done) begin
               state_nx = RST_PULSE;
               cnt_nx   = PULSE_CNT;
            end
         end
         RST_PULSE: begin
            if (cnt == CNT_W'(1)) begin
               state_nx = COOLDOWN;
               cnt_nx   = OFF_CNT;
            end
         end
         COOLDOWN: begin
            if (cnt == CNT_W'(1)) state_nx = OFF;
         end
         default: begin
            state_nx = RST_PULSE;
            cnt_nx   = PULSE_CNT;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RST_PULSE;
         cnt     <= PULSE_CNT;
         S       <= 1'b0;
         R       <= 1'b1;
         mag_on  <= 1'b0;
         cooling <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         S       <= (state_nx == SET_PULSE);
         R       <= (state_nx == RST_PULSE);
         mag_on  <= (state_nx == SET_PULSE) || (state_nx == ON);
         cooling <= (state_nx == COOLDOWN);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_magnetron_sr_driver.sv
// ============================================================================
// tb_magnetron_sr_driver : scoreboard bench with a pulse-timeline reference
// model; directed scenarios followed by randomized button/door/timer traffic.
// ============================================================================
`default_nettype none

module tb_magnetron_sr_driver;

   localparam int PL  = 2;
   localparam int MOC = 16;
   localparam int DEB = 4;
`ifdef MAGNETRON_DEBOUNCE_EN
   localparam int LAT = DEB;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0, timer_done = 1'b0;
   logic S, R, mag_on, cooling;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   magnetron_sr_driver #(.PULSE_LEN(PL), .MIN_OFF_CYCLES(MOC), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
      .door_open(door_open), .timer_done(timer_done),
      .S(S), .R(R), .mag_on(mag_on), .cooling(cooling)
   );

   initial forever #5 clk = ~clk;

   // Reference: remaining cycles of each pulse / cooldown phase, plus an "on" flag
   int s_left, r_left, cool_left;
   bit on_flag;
   bit st_prev, sp_prev, st_f, sp_f;
   int st_n, sp_n;

   task automatic model_reset();
      s_left = 0; r_left = PL; cool_left = 0; on_flag = 0;
      st_prev = 0; sp_prev = 0; st_f = 0; sp_f = 0; st_n = 0; sp_n = 0;
   endtask

   task automatic filt_step(input bit raw, inout bit f, inout int n);
      if (raw != f) begin
         n++;
         if (n == DEB) begin f = raw; n = 0; end
      end else n = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit door, input bit tmr);
      bit st_v, sp_v, st_rise, sp_rise;
`ifdef MAGNETRON_DEBOUNCE_EN
      st_v = st_f; sp_v = sp_f;
`else
      st_v = st; sp_v = sp;
`endif
      st_rise = st_v & ~st_prev;
      sp_rise = sp_v & ~sp_prev;
      st_prev = st_v; sp_prev = sp_v;
`ifdef MAGNETRON_DEBOUNCE_EN
      filt_step(st, st_f, st_n);
      filt_step(sp, sp_f, sp_n);
`endif
      if (s_left > 0) begin
         if (door) begin s_left = 0; r_left = PL; end
         else if (s_left == 1) begin s_left = 0; on_flag = 1; end
         else s_left--;
      end else if (on_flag) begin
         if (sp_rise || door || tmr) begin on_flag = 0; r_left = PL; end
      end else if (r_left > 0) begin
         if (r_left == 1) begin r_left = 0; cool_left = MOC; end
         else r_left--;
      end else if (cool_left > 0) begin
         cool_left--;
      end else if (st_rise && !door && !tmr) begin
         s_left = PL;
      end
   endtask

   function automatic logic [3:0] model_out();
      return {s_left > 0, r_left > 0, (s_left > 0) || on_flag, cool_left > 0};
   endfunction

   task automatic drive(input bit rn, input bit st, input bit sp, input bit door, input bit tmr);
      @(negedge clk);
      rst_n = rn; start_btn = st; stop_btn = sp; door_open = door; timer_done = tmr;
      if (!rn) model_reset();
      else     model_step(st, sp, door, tmr);
      exp_q.push_back(model_out());
   endtask

   task automatic hold(input int n);
      repeat (n) drive(1'b1, start_btn, stop_btn, door_open, timer_done);
   endtask

   // Monitor: compare one expected output word after every rising edge
   always @(posedge clk) begin
      logic [3:0] e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({S, R, mag_on, cooling} !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got S,R,mag_on,cooling=%b exp=%b", $time,
                     {S, R, mag_on, cooling}, e);
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (S === 1'b1 && R === 1'b1) begin
         errors++;
         $display("FAIL sr_exclusive t=%0t got S=1 R=1 exp not both high", $time);
      end
   end

   initial begin
      model_reset();
      repeat (3) drive(1'b0, 0, 0, 0, 0);
      repeat (22) drive(1'b1, 0, 0, 0, 0);

      // start, run, stop ten cycles later
      drive(1'b1, 1, 0, 0, 0);
      hold(LAT + PL + 10);
      drive(1'b1, 1, 1, 0, 0);
      hold(LAT + 3);
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + PL + MOC + 4);

      // door opens during the first S cycle
      drive(1'b1, 1, 0, 0, 0);
      hold(LAT);
      drive(1'b1, 1, 0, 1, 0);
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + PL + MOC + 4);

      // start pressed in cycle 5 of cooldown is dropped
      drive(1'b1, 1, 0, 0, 0);
      hold(LAT + PL + 3);
      drive(1'b1, 0, 1, 0, 0);
      hold(LAT + PL + 4 - 1);
      drive(1'b1, 1, 1, 0, 0);
      hold(LAT + MOC + 6);
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + 3);

      // stop and timer together in ON
      drive(1'b1, 1, 0, 0, 0);
      hold(LAT + PL + 3);
      drive(1'b1, 0, 1, 0, 1);
      hold(LAT + 3);
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + PL + MOC + 4);

      // start together with door open in OFF
      drive(1'b1, 1, 0, 1, 0);
      hold(LAT + 4);
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + 3);

      for (int i = 0; i < 1500; i++) begin
         bit st, sp, dr, tm;
         st = start_btn ^ ($urandom_range(7) == 0);
         sp = stop_btn ^ ($urandom_range(15) == 0);
         dr = door_open ^ ($urandom_range(39) == 0);
         tm = timer_done ^ ($urandom_range(29) == 0);
         drive(1'b1, st, sp, dr, tm);
      end

      // asynchronous reset in ON
      drive(1'b1, 0, 0, 0, 0);
      hold(LAT + PL + MOC + 4);
      drive(1'b1, 1, 0, 0, 0);
      hold(LAT + PL + 3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({S, R, mag_on, cooling} !== 4'b0100) begin
         errors++;
         $display("FAIL async_reset got S,R,mag_on,cooling=%b exp=0100", {S, R, mag_on, cooling});
      end
      drive(1'b0, 0, 0, 0, 0);
      drive(1'b0, 0, 0, 0, 0);
      repeat (24) drive(1'b1, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
